intersection_phase_sched: RTL and testbench

- Clocked four-approach (N/S/E/W) traffic phase scheduler.
- Latches per-approach car requests and grants the intersection to one axis at a time: NS phase or EW phase.
- Each grant runs a bounded green interval, then yellow, then all-red clearance.
- Sits between the road sensors and the lamp drivers, and is the synchronous successor to the free-running N/S/E controller.

---
 rtl/intersection_phase_sched.sv | 172 +++++++++++++++++
 tb/tb_intersection_phase_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_sched.sv
// Four-approach traffic phase scheduler: latches per-approach car requests and
// grants one axis (NS or EW) at a time through green, yellow and all-red clearance.
module intersection_phase_sched #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       n_sense,
    input  logic       s_sense,
    input  logic       e_sense,
    input  logic       w_sense,
    output logic       n_go,
    output logic       s_go,
    output logic       e_go,
    output logic       w_go,
    output logic       ns_yellow,
    output logic       ew_yellow,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] NS_GREEN  = 3'd1;
    localparam logic [2:0] NS_YELLOW = 3'd2;
    localparam logic [2:0] CLEAR     = 3'd3;
    localparam logic [2:0] EW_GREEN  = 3'd4;
    localparam logic [2:0] EW_YELLOW = 3'd5;

    localparam logic AXIS_NS = 1'b0;
    localparam logic AXIS_EW = 1'b1;

    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LIM = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] RED_LIM = CNT_W'(ALL_RED - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic             n_req;
    logic             s_req;
    logic             e_req;
    logic             w_req;
    logic             last_served;
    logic             clr_from;
    logic             ns_pend;
    logic             ew_pend;

    assign ns_pend = n_req | s_req;
    assign ew_pend = e_req | w_req;

    // Requests are held until the approach's own green sees the lane empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_req <= 1'b0;
            s_req <= 1'b0;
            e_req <= 1'b0;
            w_req <= 1'b0;
        end else begin
            n_req <= n_sense | (n_req & (state_q != NS_GREEN));
            s_req <= s_sense | (s_req & (state_q != NS_GREEN));
            e_req <= e_sense | (e_req & (state_q != EW_GREEN));
            w_req <= w_sense | (w_req & (state_q != EW_GREEN));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ns_pend && ew_pend) begin
                    state_d = (last_served == AXIS_EW) ? NS_GREEN : EW_GREEN;
                end else if (ns_pend) begin
                    state_d = NS_GREEN;
                end else if (ew_pend) begin
                    state_d = EW_GREEN;
                end
            end
            NS_GREEN: begin
                if (cnt >= MIN_LIM && (!ns_pend || (ew_pend && cnt >= MAX_LIM))) begin
                    state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (cnt == YEL_LIM) begin
                    state_d = CLEAR;
                end
            end
            EW_GREEN: begin
                if (cnt >= MIN_LIM && (!ew_pend || (ns_pend && cnt >= MAX_LIM))) begin
                    state_d = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (cnt == YEL_LIM) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // The opposing axis gets first claim on the intersection after clearance.
                if (cnt == RED_LIM) begin
                    if (clr_from == AXIS_NS) begin
                        state_d = ew_pend ? EW_GREEN : (ns_pend ? NS_GREEN : IDLE);
                    end else begin
                        state_d = ns_pend ? NS_GREEN : (ew_pend ? EW_GREEN : IDLE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            last_served <= AXIS_EW;
            clr_from    <= AXIS_NS;
        end else begin
            if (state_d != state_q || state_d == IDLE) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (state_d != state_q) begin
                if (state_d == NS_GREEN) begin
                    last_served <= AXIS_NS;
                end
                if (state_d == EW_GREEN) begin
                    last_served <= AXIS_EW;
                end
                if (state_d == CLEAR) begin
                    clr_from <= (state_q == EW_YELLOW) ? AXIS_EW : AXIS_NS;
                end
            end
        end
    end

    always_comb begin
        n_go      = 1'b0;
        s_go      = 1'b0;
        e_go      = 1'b0;
        w_go      = 1'b0;
        ns_yellow = 1'b0;
        ew_yellow = 1'b0;
        state     = state_q;
        case (state_q)
            NS_GREEN: begin
                n_go = 1'b1;
                s_go = 1'b1;
            end
            EW_GREEN: begin
                e_go = 1'b1;
                w_go = 1'b1;
            end
            NS_YELLOW: ns_yellow = 1'b1;
            EW_YELLOW: ew_yellow = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_phase_sched.sv
// Bench for intersection_phase_sched: directed phase sequences plus a random soak,
// with a cycle-level reference model feeding a scoreboard queue.
module tb_intersection_phase_sched;

    localparam int MIN_GREEN  = 4;
    localparam int MAX_GREEN  = 12;
    localparam int YELLOW     = 2;
    localparam int ALL_RED    = 1;
    localparam int CNT_W      = 4;
    localparam int LIVE_BOUND = MAX_GREEN + YELLOW + ALL_RED + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       n_sense = 1'b0;
    logic       s_sense = 1'b0;
    logic       e_sense = 1'b0;
    logic       w_sense = 1'b0;
    logic       n_go, s_go, e_go, w_go;
    logic       ns_yellow, ew_yellow;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] sb_q[$];

    // Reference model: m_el counts cycles spent in the current state, including this one.
    int       m_st;
    int       m_el;
    bit [3:0] m_req;
    bit       m_last;
    bit       m_from;
    int       prev_st;
    int       deadline[4];
    bit       live_on = 1'b0;

    intersection_phase_sched #(
        .MIN_GREEN(MIN_GREEN),
        .MAX_GREEN(MAX_GREEN),
        .YELLOW   (YELLOW),
        .ALL_RED  (ALL_RED),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .n_sense  (n_sense),
        .s_sense  (s_sense),
        .e_sense  (e_sense),
        .w_sense  (w_sense),
        .n_go     (n_go),
        .s_go     (s_go),
        .e_go     (e_go),
        .w_go     (w_go),
        .ns_yellow(ns_yellow),
        .ew_yellow(ew_yellow),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_el    = 0;
        m_req   = '0;
        m_last  = 1'b1;
        m_from  = 1'b0;
        prev_st = 0;
        sb_q.delete();
        for (int i = 0; i < 4; i++) deadline[i] = -1;
    endtask

    task automatic model_step(input logic [3:0] sns);
        bit ns_p, ew_p, own, oth;
        int nxt;
        ns_p = m_req[0] | m_req[1];
        ew_p = m_req[2] | m_req[3];
        nxt  = m_st;
        case (m_st)
            0: begin
                if (ns_p && ew_p) nxt = m_last ? 1 : 4;
                else if (ns_p) nxt = 1;
                else if (ew_p) nxt = 4;
            end
            1, 4: begin
                own = (m_st == 1) ? ns_p : ew_p;
                oth = (m_st == 1) ? ew_p : ns_p;
                if (m_el >= MIN_GREEN && (!own || (oth && m_el >= MAX_GREEN))) nxt = m_st + 1;
            end
            2, 5: if (m_el >= YELLOW) nxt = 3;
            3: begin
                if (m_el >= ALL_RED) begin
                    if (m_from) nxt = ns_p ? 1 : (ew_p ? 4 : 0);
                    else        nxt = ew_p ? 4 : (ns_p ? 1 : 0);
                end
            end
            default: nxt = 0;
        endcase
        for (int i = 0; i < 4; i++)
            m_req[i] = sns[i] | (m_req[i] & !((i < 2) ? (m_st == 1) : (m_st == 4)));
        if (nxt == 3 && m_st != 3) m_from = (m_st == 5);
        if (nxt == 1 && m_st != 1) m_last = 1'b0;
        if (nxt == 4 && m_st != 4) m_last = 1'b1;
        m_el = (nxt != m_st) ? 1 : m_el + 1;
        m_st = nxt;
        sb_q.push_back({3'(m_st), m_st == 1, m_st == 1, m_st == 4, m_st == 4, m_st == 2, m_st == 5});
    endtask

    // Called at a falling edge; returns at the next falling edge after one rising edge.
    task automatic tick(input bit n, input bit s, input bit e, input bit w);
        logic [8:0] exp_v, obs_v;
        logic [3:0] sv, gv;
        int         bound;
        sv = {w, e, s, n};
        n_sense = n; s_sense = s; e_sense = e; w_sense = w;
        model_step(sv);
        @(posedge clk);
        #1;
        cyc++;
        obs_v = {state, n_go, s_go, e_go, w_go, ns_yellow, ew_yellow};
        exp_v = sb_q.pop_front();
        check("scoreboard", 32'(obs_v), 32'(exp_v));
        check("mutex", 32'((n_go | s_go | ns_yellow) & (e_go | w_go | ew_yellow)), 32'd0);
        if ((state == 3'd2 || state == 3'd5) && prev_st != 32'(state))
            check("yellow_entry", 32'(prev_st), 32'(state) - 32'd1);
        prev_st = 32'(state);
        if (live_on) begin
            gv = {w_go, e_go, s_go, n_go};
            for (int i = 0; i < 4; i++) begin
                if (deadline[i] >= 0 && (gv[i] || cyc >= deadline[i])) begin
                    check($sformatf("liveness_%0d", i), 32'(gv[i]), 32'd1);
                    deadline[i] = -1;
                end
                if (sv[i] && deadline[i] < 0 && !gv[i]) begin
                    // A sense landing in its own axis's yellow also waits out that yellow.
                    bound = ((i < 2) ? (m_st == 2) : (m_st == 5)) ? LIVE_BOUND + YELLOW : LIVE_BOUND;
                    deadline[i] = cyc + bound;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        n_sense = 1'b0; s_sense = 1'b0; e_sense = 1'b0; w_sense = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({state, n_go, s_go, e_go, w_go, ns_yellow, ew_yellow}), 32'd0);
        check("rst_reqs", 32'({dut.n_req, dut.s_req, dut.e_req, dut.w_req}), 32'd0);
        check("rst_cnt", 32'(dut.cnt), 32'd0);
        check("rst_last_served_ew", 32'(dut.last_served), 32'd1);
        rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    initial begin
        int t1_st[9] = '{0, 1, 1, 1, 1, 2, 2, 3, 0};
        model_reset();

        // Single-cycle north request from idle.
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            tick(k == 1, 0, 0, 0);
            check($sformatf("t1_state_e%0d", k), 32'(state), 32'(t1_st[k-1]));
            if (k == 2) check("t1_nreq_e2", 32'(dut.n_req), 32'd1);
            if (k == 3) check("t1_nreq_e3", 32'(dut.n_req), 32'd0);
        end

        // North held, east pulsed: NS green capped at MAX_GREEN.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick(1, 0, k == 3, 0);
            if (k >= 2 && k <= 13) check($sformatf("t2_ns_green_e%0d", k), 32'(state), 32'd1);
            if (k == 14 || k == 15) check("t2_ns_yellow", 32'(ns_yellow), 32'd1);
            if (k == 16) check("t2_clear", 32'(state), 32'd3);
            if (k == 17) check("t2_ew_go", 32'({e_go, w_go}), 32'd3);
        end
        repeat (30) tick(0, 0, 0, 0);
        check("t2_drain_idle", 32'(state), 32'd0);

        // Simultaneous requests alternate from last_served.
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            tick(k == 1 || k == 17 || k == 33 || k == 42, 0, k == 1 || k == 17 || k == 42, 0);
            if (k == 2)  check("t3_ns_first", 32'(state), 32'd1);
            if (k == 8)  check("t3_clear", 32'(state), 32'd3);
            if (k == 9)  check("t3_ew_second", 32'(state), 32'd4);
            if (k == 16) check("t3_idle", 32'(state), 32'd0);
            if (k == 18) check("t3_pair2_ns", 32'(state), 32'd1);
            if (k == 25) check("t3_pair2_ew", 32'(state), 32'd4);
            if (k == 32) check("t3_idle2", 32'(state), 32'd0);
            if (k == 41) check("t3_idle3", 32'(state), 32'd0);
            if (k == 43) check("t3_pair3_ew_first", 32'(state), 32'd4);
            if (k == 50) check("t3_pair3_ns_next", 32'(state), 32'd1);
        end

        // West held, south pulsed during EW green; EW re-granted after NS drains.
        do_reset();
        for (int k = 1; k <= 44; k++) begin
            tick(0, k == 3 || k == 7, 0, 1);
            if (k >= 2 && k <= 13) check($sformatf("t4_ew_green_e%0d", k), 32'(state), 32'd4);
            if (k == 14) check("t4_ew_yellow", 32'(state), 32'd5);
            if (k == 16) check("t4_clear", 32'(state), 32'd3);
            if (k == 17 || k == 20) check("t4_ns_green", 32'(state), 32'd1);
            if (k == 21) check("t4_ns_yellow", 32'(state), 32'd2);
            if (k == 24) check("t4_ew_regrant", 32'(state), 32'd4);
            if (k == 44) check("t4_ew_hold", 32'(state), 32'd4);
        end
        check("t4_cnt_saturated", 32'(dut.cnt), 32'd15);

        // Asynchronous reset in the middle of NS yellow.
        do_reset();
        for (int k = 1; k <= 6; k++) tick(k == 1, 0, k == 3, 0);
        check("t5_in_yellow", 32'(state), 32'd2);
        check("t5_ereq_before", 32'(dut.e_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_outputs", 32'({state, n_go, s_go, e_go, w_go, ns_yellow, ew_yellow}), 32'd0);
        check("t5_async_reqs", 32'({dut.n_req, dut.s_req, dut.e_req, dut.w_req}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 6; k++) tick(0, 0, 0, 0);
        check("t5_stays_idle", 32'(state), 32'd0);

        // Random soak with mutex and bounded-grant checks.
        do_reset();
        live_on = 1'b1;
        for (int k = 0; k < 10000; k++)
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        repeat (LIVE_BOUND + YELLOW + 2) tick(0, 0, 0, 0);
        live_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
